t_skew_accum: RTL and testbench

T_SKEW_ACCUM -- requirements
Module: t_skew_accum

---
 rtl/t_skew_pkg.sv | 23 ++
 rtl/t_skew_accum_if.sv | 36 +++
 rtl/t_skew_chain.sv | 35 +++
 rtl/t_skew_accum.sv | 171 +++++++++++++++++
 tb/tb_t_skew_accum.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/t_skew_pkg.sv
// rtl/t_skew_pkg.sv - shared state encoding and width helpers for the skew accumulator
package t_skew_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int cw_f(input int stages);
        return $clog2(stages + 1);
    endfunction

    function automatic int sw_f(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int aw_f(input int stages, input int log2_n);
        return cw_f(stages) + log2_n;
    endfunction

endpackage

// File: rtl/t_skew_accum_if.sv
// rtl/t_skew_accum_if.sv - request/result bundle between a measurement client and the accumulator
interface t_skew_accum_if #(
    parameter int STAGES   = 64,
    parameter int CHANNELS = 4,
    parameter int LOG2_N   = 4
);
    import t_skew_pkg::*;

    localparam int CW = cw_f(STAGES);
    localparam int SW = sw_f(CHANNELS);
    localparam int AW = aw_f(STAGES, LOG2_N);

    logic          start;
    logic [SW-1:0] ch_sel;
    logic          cont;
    logic          busy;
    logic          sel_err;
    logic          res_valid;
    logic          res_ready;
    logic [SW-1:0] res_ch;
    logic [CW-1:0] res_avg;
    logic [CW-1:0] res_min;
    logic [CW-1:0] res_max;
    logic [AW-1:0] res_sum;

    modport master (
        output start, ch_sel, cont, res_ready,
        input  busy, sel_err, res_valid, res_ch, res_avg, res_min, res_max, res_sum
    );

    modport slave (
        input  start, ch_sel, cont, res_ready,
        output busy, sel_err, res_valid, res_ch, res_avg, res_min, res_max, res_sum
    );

endinterface

// File: rtl/t_skew_chain.sv
// rtl/t_skew_chain.sv - one inverter-pair delay line with its tap sampling register
module t_skew_chain #(
    parameter int STAGES = 64
) (
    input  logic              clk_b,
    input  logic              rst_n,
    input  logic              clk_a,
    output logic [STAGES:0]   samp
);

    logic [STAGES:0] tap;

    // Each stage keeps its own nets so the inverter pairs survive synthesis.
    for (genvar i = 0; i <= STAGES; i++) begin : g_stage
        (* keep = "true", dont_touch = "true" *) logic inv_n;
        (* keep = "true", dont_touch = "true" *) logic out_w;
        if (i == 0) begin : g_head
            assign inv_n = ~clk_a;
            assign out_w = clk_a;
        end else begin : g_body
            assign inv_n = ~g_stage[i-1].out_w;
            assign out_w = ~inv_n;
        end
        assign tap[i] = out_w;
    end

    always_ff @(posedge clk_b) begin
        if (!rst_n) begin
            samp <= '0;
        end else begin
            samp <= tap;
        end
    end

endmodule

// File: rtl/t_skew_accum.sv
// rtl/t_skew_accum.sv - per-channel skew sampling with windowed sum/avg/min/max of tap popcounts
module t_skew_accum
    import t_skew_pkg::*;
#(
    parameter int STAGES   = 64,
    parameter int CHANNELS = 4,
    parameter int LOG2_N   = 4
) (
    input  logic                clk_b,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] clk_a,
    t_skew_accum_if.slave       bus
);

    localparam int CW   = cw_f(STAGES);
    localparam int SW   = sw_f(CHANNELS);
    localparam int AW   = aw_f(STAGES, LOG2_N);
    localparam int CNTW = LOG2_N + 1;
    localparam logic [CNTW-1:0] LAST = CNTW'((1 << LOG2_N) - 1);

    logic [STAGES:0]     samp [CHANNELS];
    logic [CHANNELS-1:0] unused_tap0;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        t_skew_chain #(.STAGES(STAGES)) u_chain (
            .clk_b (clk_b),
            .rst_n (rst_n),
            .clk_a (clk_a[c]),
            .samp  (samp[c])
        );
        assign unused_tap0[c] = samp[c][0];
    end

    state_t          state;
    logic [SW-1:0]   ch;
    logic [CNTW-1:0] cnt;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   mn;
    logic [CW-1:0]   mx;
    logic [CW-1:0]   code;
    logic            busy_q;
    logic            sel_err_q;
    logic            res_valid_q;
    logic [SW-1:0]   res_ch_q;
    logic [CW-1:0]   res_avg_q;
    logic [CW-1:0]   res_min_q;
    logic [CW-1:0]   res_max_q;
    logic [AW-1:0]   res_sum_q;

    logic [STAGES:1] sel_taps;
    logic [CW-1:0]   pop;
    logic [AW-1:0]   acc_nx;
    logic [CW-1:0]   mn_nx;
    logic [CW-1:0]   mx_nx;
    logic            sel_ok;

    // Popcount rather than thermometer decode so a bubble costs one count, not the whole code.
    always_comb begin
        sel_taps = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch == SW'(c)) sel_taps = samp[c][STAGES:1];
        end
        pop = '0;
        for (int i = 1; i <= STAGES; i++) begin
            pop = pop + CW'(sel_taps[i]);
        end
    end

    always_comb begin
        acc_nx = acc + AW'(code);
        mn_nx  = (code < mn) ? code : mn;
        mx_nx  = (code > mx) ? code : mx;
        sel_ok = (32'(bus.ch_sel) < CHANNELS);
    end

    always_ff @(posedge clk_b) begin
        if (!rst_n) begin
            code <= '0;
        end else begin
            code <= pop;
        end
    end

    always_ff @(posedge clk_b) begin
        if (!rst_n) begin
            state       <= IDLE;
            ch          <= '0;
            cnt         <= '0;
            acc         <= '0;
            mn          <= '1;
            mx          <= '0;
            busy_q      <= 1'b0;
            sel_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_avg_q   <= '0;
            res_min_q   <= '0;
            res_max_q   <= '0;
            res_sum_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (sel_ok) begin
                            ch        <= bus.ch_sel;
                            acc       <= '0;
                            mn        <= '1;
                            mx        <= '0;
                            cnt       <= '0;
                            sel_err_q <= 1'b0;
                            busy_q    <= 1'b1;
                            state     <= FLUSH;
                        end else begin
                            sel_err_q <= 1'b1;
                        end
                    end
                end
                // Two cycles let the tap register and the code register both reload for this channel.
                FLUSH: begin
                    if (cnt == CNTW'(1)) begin
                        cnt   <= '0;
                        state <= ACCUM;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                ACCUM: begin
                    acc <= acc_nx;
                    mn  <= mn_nx;
                    mx  <= mx_nx;
                    cnt <= cnt + CNTW'(1);
                    if (cnt == LAST) begin
                        state       <= DONE;
                        res_valid_q <= 1'b1;
                        res_sum_q   <= acc_nx;
                        res_avg_q   <= CW'(acc_nx >> LOG2_N);
                        res_min_q   <= mn_nx;
                        res_max_q   <= mx_nx;
                        res_ch_q    <= ch;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        if (bus.cont) begin
                            acc   <= '0;
                            mn    <= '1;
                            mx    <= '0;
                            cnt   <= '0;
                            state <= FLUSH;
                        end else begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.sel_err   = sel_err_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_ch    = res_ch_q;
    assign bus.res_avg   = res_avg_q;
    assign bus.res_min   = res_min_q;
    assign bus.res_max   = res_max_q;
    assign bus.res_sum   = res_sum_q;

endmodule

// File: tb/tb_t_skew_accum.sv
// tb/tb_t_skew_accum.sv - directed self-checking bench for t_skew_accum
module tb_t_skew_accum;

    localparam int STAGES   = 64;
    localparam int CHANNELS = 3;
    localparam int LOG2_N   = 4;

    logic                clk_b = 1'b0;
    logic                rst_n = 1'b0;
    logic [CHANNELS-1:0] clk_a = 3'b100;

    int checks   = 0;
    int failures = 0;

    t_skew_accum_if #(.STAGES(STAGES), .CHANNELS(CHANNELS), .LOG2_N(LOG2_N)) bus ();

    t_skew_accum #(.STAGES(STAGES), .CHANNELS(CHANNELS), .LOG2_N(LOG2_N)) dut (
        .clk_b (clk_b),
        .rst_n (rst_n),
        .clk_a (clk_a),
        .bus   (bus)
    );

    always #5 clk_b = ~clk_b;

    task automatic tick();
        @(posedge clk_b);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.res_valid && n < 60);
    endtask

    task automatic chk_result(input string tag, input int avg, input int mn, input int mx,
                              input int sum, input int ch);
        chk({tag, "_avg"}, 64'(bus.res_avg), 64'(avg));
        chk({tag, "_min"}, 64'(bus.res_min), 64'(mn));
        chk({tag, "_max"}, 64'(bus.res_max), 64'(mx));
        chk({tag, "_sum"}, 64'(bus.res_sum), 64'(sum));
        chk({tag, "_ch"},  64'(bus.res_ch),  64'(ch));
    endtask

    initial begin
        int  n;
        bit  busy_ok;
        bit  stable_ok;
        bit  seen_valid;

        bus.start     = 1'b0;
        bus.ch_sel    = '0;
        bus.cont      = 1'b0;
        bus.res_ready = 1'b0;

        // Reset values
        tick();
        tick();
        chk("rst_busy",    64'(bus.busy),      64'd0);
        chk("rst_valid",   64'(bus.res_valid), 64'd0);
        chk("rst_sel_err", 64'(bus.sel_err),   64'd0);
        chk_result("rst", 0, 0, 0, 0, 0);
        chk("rst_code",    64'(dut.code),      64'd0);
        rst_n = 1'b1;
        tick();

        // Invalid channel select is flagged and does not start a window
        bus.start  = 1'b1;
        bus.ch_sel = 2'd3;
        tick();
        bus.start = 1'b0;
        chk("bad_sel_err",  64'(bus.sel_err), 64'd1);
        chk("bad_sel_busy", 64'(bus.busy),    64'd0);
        tick();
        chk("bad_sel_idle", 64'(bus.busy),    64'd0);

        // Channel 2 tied high: every tap set, code 64 each sample
        bus.start  = 1'b1;
        bus.ch_sel = 2'd2;
        tick();
        bus.start = 1'b0;
        chk("start_clr_err", 64'(bus.sel_err), 64'd0);
        chk("start_busy",    64'(bus.busy),    64'd1);
        n = 1;
        while (!bus.res_valid && n < 60) begin
            tick();
            n++;
        end
        chk("lat_ch2", 64'(n), 64'd19);
        chk_result("ch2", 64, 64, 64, 1024, 2);

        // Hold off the consumer; a start pulse in DONE must be ignored
        stable_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.start  = (i == 3);
            bus.ch_sel = 2'd0;
            tick();
            if (!(bus.res_valid === 1'b1 && bus.res_sum === 11'd1024 &&
                  bus.res_ch === 2'd2 && bus.res_avg === 7'd64)) stable_ok = 1'b0;
        end
        bus.start = 1'b0;
        chk("done_stable", 64'(stable_ok), 64'd1);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk("hs_valid_low", 64'(bus.res_valid), 64'd0);
        chk("hs_idle",      64'(bus.busy),      64'd0);
        chk("hs_retain",    64'(bus.res_sum),   64'd1024);
        tick();
        chk("hs_no_start",  64'(bus.busy),      64'd0);

        // Reset pulse mid-ACCUM aborts the window
        bus.start  = 1'b1;
        bus.ch_sel = 2'd2;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("pre_rst_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy",  64'(bus.busy),      64'd0);
        chk("abort_valid", 64'(bus.res_valid), 64'd0);
        chk_result("abort", 0, 0, 0, 0, 0);
        seen_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) seen_valid = 1'b1;
        end
        chk("abort_quiet", 64'(seen_valid), 64'd0);

        // Channel 1 taps forced: taps 1,2,4,5 set, tap 3 a bubble -> code 4
        force dut.g_ch[1].u_chain.samp = 65'b110110;
        bus.start  = 1'b1;
        bus.ch_sel = 2'd1;
        tick();
        bus.start = 1'b0;
        wait_valid(n);
        chk("lat_ch1", 64'(n), 64'd18);
        chk_result("bubble", 4, 4, 4, 64, 1);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        release dut.g_ch[1].u_chain.samp;
        chk("bubble_idle", 64'(bus.busy), 64'd0);

        // Continuous mode on channel 0 tied low, consumer always ready
        bus.cont      = 1'b1;
        bus.res_ready = 1'b1;
        bus.start     = 1'b1;
        bus.ch_sel    = 2'd0;
        busy_ok       = 1'b1;
        for (int r = 0; r < 3; r++) begin
            n = 0;
            do begin
                tick();
                bus.start = 1'b0;
                n++;
                if (bus.busy !== 1'b1) busy_ok = 1'b0;
            end while (!bus.res_valid && n < 60);
            chk($sformatf("cont_lat%0d", r), 64'(n), 64'd19);
            chk_result($sformatf("cont%0d", r), 0, 0, 0, 0, 0);
        end
        chk("cont_busy", 64'(busy_ok), 64'd1);
        bus.cont = 1'b0;
        tick();
        bus.res_ready = 1'b0;
        chk("cont_end_busy",  64'(bus.busy),      64'd0);
        chk("cont_end_valid", 64'(bus.res_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
